// File: rtl/adder_rr_scheduler_pkg.sv
// Shared defaults and slot-state encoding for the round-robin adder scheduler.
// The optional saturating sum is enabled with the ADDER_RR_SAT_EN macro.
package adder_sched_pkg;

  localparam int WIDTH_DEF   = 12;
  localparam int NUM_REQ_DEF = 4;

  // Requester ID width, never narrower than one bit.
  function automatic int idw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Requester and result handshake bundle between clients and the shared adder.
// The scheduler uses the slave modport; clients and the consumer use master.
interface adder_rr_scheduler_if
  import adder_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = idw_of(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic                     res_cout;
  logic [IDW-1:0]           res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id
  );

endinterface

// File: rtl/adder_rr_scheduler_adder.sv
// Full-adder ripple chain, WIDTH bits, with carry in and carry out.
module ripple_adder #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or above ptr, wrapping.
// Produces a one-hot grant, its encoded index and an any-request flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  // Scan from the farthest offset back toward ptr so the nearest hit is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IDW'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin sharing of one ripple adder among NUM_REQ requesters, one result slot.
// Define ADDER_RR_SAT_EN to saturate the sum on unsigned overflow instead of wrapping.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = idw_of(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  adder_rr_scheduler_if.slave  bus
);

  slot_state_t        state, state_nxt;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic               can_accept;
  logic               transfer;
  logic [WIDTH-1:0]   op_a, op_b, add_sum, sum_final;
  logic               add_cout;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic [IDW-1:0]     id_q;

  // A pop frees the slot in the same cycle, so a full slot with res_ready may still accept.
  assign can_accept = en & ~rst & ((state == SLOT_EMPTY) | bus.res_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign bus.req_ready = can_accept ? grant : '0;
  assign transfer      = can_accept & grant_any;
  assign op_a          = bus.req_a[int'(grant_idx) * WIDTH +: WIDTH];
  assign op_b          = bus.req_b[int'(grant_idx) * WIDTH +: WIDTH];

  ripple_adder #(.WIDTH(WIDTH)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADDER_RR_SAT_EN
  assign sum_final = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
  assign sum_final = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (transfer)                                     state_nxt = SLOT_FULL;
    else if ((state == SLOT_FULL) && bus.res_ready)   state_nxt = SLOT_EMPTY;
  end

  always_comb begin
    bus.res_valid = (state == SLOT_FULL);
  end

  // Payload and pointer move only on a transfer; a bare pop leaves them as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (transfer) begin
      sum_q  <= sum_final;
      cout_q <= add_cout;
      id_q   <= grant_idx;
      rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  assign bus.res_sum  = sum_q;
  assign bus.res_cout = cout_q;
  assign bus.res_id   = id_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed scenarios plus random traffic
// against an arithmetic reference model; honours ADDER_RR_SAT_EN when defined.
module tb_adder_rr_scheduler;
  import adder_sched_pkg::*;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef ADDER_RR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.WIDTH(W), .NUM_REQ(N), .IDW(IW)) bus ();

  adder_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .IDW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int op_a [N];
  int op_b [N];
  logic [N-1:0] cur_valid;
  logic [N-1:0] exp_ready;

  // Reference model state: pointer and slot contents as plain integers.
  int m_ptr   = 0;
  bit m_valid = 1'b0;
  bit m_cout  = 1'b0;
  int m_sum   = 0;
  int m_id    = 0;

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W+IW+1:0] exp_res();
    return {m_valid, m_cout, W'(m_sum), IW'(m_id)};
  endfunction

  function automatic logic [W+IW+1:0] got_res();
    return {bus.res_valid, bus.res_cout, bus.res_sum, bus.res_id};
  endfunction

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr, input logic e, input logic r);
    int g;
    @(negedge clk);
    rst = r;
    en = e;
    bus.res_ready = rr;
    bus.req_valid = v;
    cur_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = W'(op_a[i]);
      bus.req_b[i*W +: W] = W'(op_b[i]);
    end
    g = pick(m_ptr, v);
    exp_ready = (e && !r && (!m_valid || rr) && g >= 0) ? N'(1 << g) : '0;
    #1;
  endtask

  task automatic advance();
    int g;
    int total;
    if (rst) begin
      m_valid = 0; m_cout = 0; m_sum = 0; m_id = 0; m_ptr = 0;
    end else if (exp_ready != '0) begin
      g = pick(m_ptr, cur_valid);
      total = op_a[g] + op_b[g];
      m_cout = (total >= (1 << W));
      m_sum = total % (1 << W);
      if (SAT && m_cout) m_sum = (1 << W) - 1;
      m_id = g;
      m_valid = 1;
      m_ptr = (g + 1) % N;
    end else if (m_valid && bus.res_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus('1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.req_ready !== '0) begin
      errors++; $display("[TB] FAIL reset_ready: got %b, expected 0000", bus.req_ready);
    end
    advance();
    checks++;
    if (got_res() !== '0) begin
      errors++; $display("[TB] FAIL reset_state: got %h, expected 0", got_res());
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin op_a[i] = i * 256 + 1; op_b[i] = 2; end
    for (int k = 0; k < 5; k++) begin
      applyStimulus('1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.req_ready !== N'(1 << order[k])) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %b, expected %b", k, bus.req_ready, N'(1 << order[k]));
      end
      advance();
      checks++;
      if (got_res() !== {1'b1, 1'b0, W'(order[k] * 256 + 3), IW'(order[k])}) begin
        errors++; $display("[TB] FAIL rr_result%0d: got %h, expected %h", k, got_res(), {1'b1, 1'b0, W'(order[k] * 256 + 3), IW'(order[k])});
      end
    end
  endtask

  task automatic test_overflow();
    op_a[2] = 'h800; op_b[2] = 'h800;
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL ovf_grant: got %b, expected 0100", bus.req_ready);
    end
    advance();
    checks++;
    if ({bus.res_cout, bus.res_sum, bus.res_id} !== {1'b1, SAT ? 12'hFFF : 12'h000, 2'd2}) begin
      errors++; $display("[TB] FAIL ovf_result: got %h, expected %h", {bus.res_cout, bus.res_sum, bus.res_id}, {1'b1, SAT ? 12'hFFF : 12'h000, 2'd2});
    end
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    advance();
    checks++;
    if (got_res() !== exp_res() || bus.res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_drain: got %h, expected %h", got_res(), exp_res());
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    op_a[1] = int'($urandom_range(0, 4095)); op_b[1] = int'($urandom_range(0, 4095));
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
    advance();
    held = bus.res_sum;
    checks++;
    if (got_res() !== exp_res()) begin
      errors++; $display("[TB] FAIL bp_fill: got %h, expected %h", got_res(), exp_res());
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.req_ready !== '0) begin
        errors++; $display("[TB] FAIL bp_ready%0d: got %b, expected 0000", k, bus.req_ready);
      end
      advance();
      checks++;
      if (bus.res_sum !== W'(m_sum) || bus.res_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold%0d: got %h/%b, expected %h/1 (held %h)", k, bus.res_sum, bus.res_valid, m_sum, held);
      end
    end
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL bp_release: got %b, expected 0010", bus.req_ready);
    end
    advance();
    checks++;
    if (got_res() !== exp_res() || bus.res_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_poppush: got %h, expected %h", got_res(), exp_res());
    end
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_enable();
    op_a[3] = 'h123; op_b[3] = 'h456;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.req_ready !== '0) begin
        errors++; $display("[TB] FAIL en_off%0d: got %b, expected 0000", k, bus.req_ready);
      end
      advance();
    end
    applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("[TB] FAIL en_on: got %b, expected 1000", bus.req_ready);
    end
    advance();
    checks++;
    if (got_res() !== {1'b1, 1'b0, 12'h579, 2'd3}) begin
      errors++; $display("[TB] FAIL en_result: got %h, expected %h", got_res(), {1'b1, 1'b0, 12'h579, 2'd3});
    end
    applyStimulus('1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL en_wrap: got %b, expected 0001", bus.req_ready);
    end
    advance();
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_reset_mid();
    op_a[0] = 'h5A0; op_b[0] = 'h005;
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    advance();
    checks++;
    if (got_res() !== {1'b1, 1'b0, 12'h5A5, 2'd0}) begin
      errors++; $display("[TB] FAIL rm_fill: got %h, expected %h", got_res(), {1'b1, 1'b0, 12'h5A5, 2'd0});
    end
    applyStimulus('1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.req_ready !== '0) begin
      errors++; $display("[TB] FAIL rm_ready: got %b, expected 0000", bus.req_ready);
    end
    advance();
    checks++;
    if (got_res() !== '0) begin
      errors++; $display("[TB] FAIL rm_cleared: got %h, expected 0", got_res());
    end
    applyStimulus('1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL rm_restart: got %b, expected 0001", bus.req_ready);
    end
    advance();
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_back_to_back();
    op_a[1] = 'hFFF; op_b[1] = 'h001;
    op_a[2] = 'h7FF; op_b[2] = 'h001;
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0);
    advance();
    checks++;
    if (got_res() !== {1'b1, 1'b1, SAT ? 12'hFFF : 12'h000, 2'd1}) begin
      errors++; $display("[TB] FAIL b2b_first: got %h, expected %h", got_res(), {1'b1, 1'b1, SAT ? 12'hFFF : 12'h000, 2'd1});
    end
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
    advance();
    checks++;
    if (got_res() !== {1'b1, 1'b0, 12'h800, 2'd2}) begin
      errors++; $display("[TB] FAIL b2b_second: got %h, expected %h", got_res(), {1'b1, 1'b0, 12'h800, 2'd2});
    end
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = int'($urandom_range(0, 4095));
        op_b[i] = int'($urandom_range(0, 4095));
      end
      applyStimulus(N'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 49) == 0));
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL rnd_ready%0d: got %b, expected %b", k, bus.req_ready, exp_ready);
      end
      advance();
      checks++;
      if (got_res() !== exp_res()) begin
        errors++; $display("[TB] FAIL rnd_result%0d: got %h, expected %h", k, got_res(), exp_res());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;
    cur_valid = '0;
    exp_ready = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = 0; op_b[i] = 0; end
    test_reset();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one 12-bit ripple-carry adder datapath among NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake. The granted pair is added, and the sum is held in a single registered output slot tagged with the requester ID.
- Sits between multiple compute clients and the shared adder. Replaces per-client adders where area matters.

Parameters:
- WIDTH, 12, operand and sum width.
- NUM_REQ, 4, number of requesters (2..8).
- IDW, $clog2(NUM_REQ) (min 1), width of the requester ID.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  global enable; when low, no new grants are issued and the output slot holds its value.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
- res_valid  output  1  result slot full.
- res_ready  input  1  downstream accepts the result.
- res_sum  output  WIDTH  registered sum.
- res_cout  output  1  registered carry out of the MSB.
- res_id  output  IDW  index of the requester that produced res_sum.

Behaviour:
- Reset (rst=1 at a clk edge):
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, rr_ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-transaction discards the held result. No grant is issued in the reset cycle.
- Slot state: EMPTY (res_valid=0) or FULL (res_valid=1).
- can_accept = en & ~rst & (~res_valid | res_ready). A pop and a push may occur in the same cycle.
- Arbitration:
  - Search req_valid starting at rr_ptr and ascending modulo NUM_REQ. The first asserted index g wins.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - With no valid request, req_ready = 0.
- Transfer: a transfer occurs when req_valid[g] & req_ready[g]. On that edge:
  - {res_cout,res_sum} <= req_a[g] + req_b[g], carry-in 0, unsigned, wraps modulo 2^WIDTH.
  - res_id <= g, res_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr changes only on a transfer. A requester that was just served has the lowest priority on the next cycle, so no requester starves while its valid is held.
- Pop only (res_valid & res_ready, no transfer): res_valid <= 0; sum, carry and ID hold their last values.
- FULL with res_ready=0: no grant, output held stable. A requester must hold valid and data stable until it sees ready.
- en=0: no grants. A pending result may still be popped by res_ready. rr_ptr holds.
- Latency: one cycle from accept edge to res_valid. Throughput: one sum per cycle when res_ready is held high.

Optional Feature:
- Macro: ADDER_RR_SAT_EN.
- When defined, the sum saturates on unsigned overflow: if the carry is 1, res_sum <= {WIDTH{1'b1}}. res_cout still reports the overflow.
- When undefined, the sum wraps modulo 2^WIDTH; res_cout carries the overflow bit.

Decomposition:
- Package adder_sched_pkg holds: WIDTH default, NUM_REQ default, IDW derivation, slot-state encoding (SLOT_EMPTY, SLOT_FULL).
- Sub-module rr_arbiter: combinational round-robin priority pick from req_valid and rr_ptr, giving a one-hot grant and encoded index.
- The adder is the team's existing full-adder ripple chain, instantiated once at WIDTH bits.

Test Plan:
- Reset, then all four requesters valid with A=i*0x100+1, B=2, res_ready=1 -> grants in order 0,1,2,3,0. res_id follows one cycle later. Requester 0's first sum is 0x003.
- Requester 2 only: A=0x800, B=0x800 -> res_sum=0x000, res_cout=1. With ADDER_RR_SAT_EN defined, res_sum=0xFFF, res_cout=1.
- Slot FULL, res_ready=0 for 3 cycles, req 1 valid -> req_ready=0 throughout and res_sum stable. Raise res_ready -> pop and new push on the same edge, so res_valid stays 1.
- en=0 with req 3 valid, slot empty -> no req_ready and rr_ptr unchanged. en=1 -> req 3 granted, and the next grant search starts at 0.
- rst asserted while res_valid=1 (sum 0x5A5) -> next cycle res_valid=0 and res_sum=0. After release, arbitration restarts at requester 0.
- A=0xFFF, B=0x001 from req 1, then A=0x7FF, B=0x001 from req 2, back-to-back -> results {1,0x000} then {0,0x800}, IDs 1 then 2.
